pipeline_hazard_unit: RTL and testbench
=======================================

# pipeline_hazard_unit

Parametrised hazard and bypass controller for the pipelined MIPS core. It tracks destination registers of in-flight instructions through a configurable number of post-decode stages and drives the decode-stage bypass selects for rs and rt. It detects load-use hazards against a configurable load-data stage, raises a stall, and inserts bubbles. It also annuls killed instructions and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- REG_AW, 5, register address width
- STAGES, 3, tracked post-decode stages: 1=EX, 2=MEM, …, STAGES=WB; valid range 2..7
- LOAD_STAGE, 2, first stage whose forwarding source carries load data; valid range 1..STAGES
- CNT_W, 16, stall counter width
- SEL_W, 2, bypass select width; must satisfy 2^SEL_W > STAGES

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid_d  in  1  decode holds a real instruction
- i_kill_d  in  1  annul the decode instruction
- i_rs, i_rt  in  REG_AW  decode source addresses
- i_use_rs, i_use_rt  in  1  instruction reads rs / rt
- i_rw_d  in  REG_AW  decode destination address
- i_regwr_d  in  1  decode instruction writes the register file
- i_memread_d  in  1  decode instruction is a load
- i_cnt_clr  in  1  synchronous clear of the stall counter
- o_asrc, o_bsrc  out  SEL_W  bypass select: 0 = register file, k = stage k result
- o_stall  out  1  hold PC and decode register; insert bubble into EX
- o_stage_regwr  out  STAGES  bit k-1 = valid and regwr of stage k
- o_wb_en  out  1  equals o_stage_regwr[STAGES-1]
- o_wb_rw  out  REG_AW  destination address at stage STAGES
- o_stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Each of the STAGES entries holds {valid, regwr, is_load, rw}. All entries are registered.
- Shift on every clock: entry k+1 <= entry k for k = 1..STAGES-1.
- Entry 1 <= {i_valid_d & ~i_kill_d & ~o_stall, i_regwr_d, i_memread_d, i_rw_d}. When valid = 0, the other fields are don't-care, and the entry never matches.
- Match rule for source s (rs or rt): stage k matches when valid_k & regwr_k & (rw_k == s) & (s != 0).
- Select rule: when the source is unused or s = 0, select = 0. Otherwise select = the smallest k that matches, so the youngest producer wins. When no stage matches, select = 0.
- Load-use rule: when the youngest match k has is_load = 1 and k < LOAD_STAGE, that source is hazardous.
- o_stall = i_valid_d & ~i_kill_d & (hazard on rs | hazard on rt).
- While o_stall = 1, the selects still show the matching stage. The datapath ignores them because the bubble discards the result.
- i_kill_d takes priority over stall. A killed instruction never stalls and enters EX as a bubble.
- A write to r0 is tracked but never forwarded.
- Stall counter: i_cnt_clr clears it to 0 and takes priority. Otherwise it increments when o_stall = 1 and holds at all-ones.

## Timing
- Reset values: all entries invalid, o_asrc = o_bsrc = 0, o_stall = 0, o_stage_regwr = 0, o_wb_en = 0, o_wb_rw = 0, o_stall_cnt = 0.
- Asserting reset mid-operation clears every in-flight entry immediately. No write-enable is emitted afterwards for instructions that were in flight.
- The selects, o_stall, o_stage_regwr and o_wb_* are combinational from the registered entries and the decode inputs, valid in the same cycle.
- An instruction decoded at cycle t occupies stage k at cycle t+k and writes back at t+STAGES.
- Load-use with default parameters: a load in EX with a dependent instruction in decode gives exactly 1 stall cycle. In the next cycle the load is in MEM and the select = 2.
- With LOAD_STAGE = L, a load followed immediately by a dependent instruction stalls for L-1 cycles.
- When rs and rt are both hazardous, there is one stall, whose length is set by the youngest hazardous producer.

## Test plan
- Reset, then an ALU op writing r5, then an op reading rs = r5 -> o_asrc = 1, o_stall = 0. Next-cycle reader -> o_asrc = 2. The reader after that -> o_asrc = 3.
- lw r7, then add using rt = r7 -> o_stall = 1 for 1 cycle, bubble in EX (o_stage_regwr[0] = 0), then o_bsrc = 2 and o_stall_cnt = 1.
- Writes to r3 in stages 1 and 3 simultaneously, reader of r3 -> o_asrc = 1 (youngest wins). A write to r0 followed by a reader of r0 -> select = 0.
- Load-use hazard with i_kill_d = 1 -> o_stall = 0 and entry 1 invalid. Hazard with i_cnt_clr = 1 -> o_stall_cnt = 0.
- STAGES = 5, LOAD_STAGE = 3, load followed immediately by a dependent op -> 2 stall cycles, then select = 3. Force 2^CNT_W stalls -> counter saturates at all-ones.
- Assert i_rst_n low while a load is in stage 2 -> all outputs reach their reset values asynchronously, and o_wb_en stays 0 after release.

Source files
------------

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
// Tracks destination registers of in-flight instructions through the
// post-decode stages and drives the decode-stage bypass selects for rs and rt.
// It also detects load-use hazards, which stall decode and insert a bubble.
// Killed decode instructions enter EX as bubbles. A saturating counter records
// the number of stall cycles.
module pipeline_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid_d,
  input  logic              i_kill_d,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic              i_use_rs,
  input  logic              i_use_rt,
  input  logic [REG_AW-1:0] i_rw_d,
  input  logic              i_regwr_d,
  input  logic              i_memread_d,
  input  logic              i_cnt_clr,
  output logic [SEL_W-1:0]  o_asrc,
  output logic [SEL_W-1:0]  o_bsrc,
  output logic              o_stall,
  output logic [STAGES-1:0] o_stage_regwr,
  output logic              o_wb_en,
  output logic [REG_AW-1:0] o_wb_rw,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  // Per-stage fields. Index k-1 holds stage k, so index 0 is EX.
  logic [STAGES-1:0]             stg_valid;
  logic [STAGES-1:0]             stg_regwr;
  logic [STAGES-1:0]             stg_load;
  logic [STAGES-1:0][REG_AW-1:0] stg_rw;

  logic [CNT_W-1:0] stall_cnt;
  logic             haz_rs;
  logic             haz_rt;
  logic [SEL_W-1:0] sel_rs;
  logic [SEL_W-1:0] sel_rt;

  // Youngest-producer search for one source operand.
  // Returns {hazard, select}. Register r0 and unused sources never forward.
  function automatic logic [SEL_W:0] lookup(
    input logic [REG_AW-1:0]             src,
    input logic                          used,
    input logic [STAGES-1:0]             v,
    input logic [STAGES-1:0]             wr,
    input logic [STAGES-1:0]             ld,
    input logic [STAGES-1:0][REG_AW-1:0] rw
  );
    logic [SEL_W-1:0] sel;
    logic             haz;
    logic             found;
    sel   = '0;
    haz   = 1'b0;
    found = 1'b0;
    if (used && (src != '0)) begin
      for (int k = 0; k < STAGES; k++) begin
        if (!found && v[k] && wr[k] && (rw[k] == src)) begin
          found = 1'b1;
          sel   = SEL_W'(k + 1);
          haz   = ld[k] && ((k + 1) < LOAD_STAGE);
        end
      end
    end
    return {haz, sel};
  endfunction

  // Bypass selects and load-use hazards from the tracked stages and decode sources.
  always_comb begin
    {haz_rs, sel_rs} = lookup(i_rs, i_use_rs, stg_valid, stg_regwr, stg_load, stg_rw);
    {haz_rt, sel_rt} = lookup(i_rt, i_use_rt, stg_valid, stg_regwr, stg_load, stg_rw);
  end

  assign o_asrc        = sel_rs;
  assign o_bsrc        = sel_rt;
  assign o_stall       = i_valid_d & ~i_kill_d & (haz_rs | haz_rt);
  assign o_stage_regwr = stg_valid & stg_regwr;
  assign o_wb_en       = o_stage_regwr[STAGES-1];
  assign o_wb_rw       = stg_rw[STAGES-1];
  assign o_stall_cnt   = stall_cnt;

  // Advance the tracking pipeline every cycle. Stalled or killed decode slots enter as bubbles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stg_valid <= '0;
      stg_regwr <= '0;
      stg_load  <= '0;
      stg_rw    <= '0;
    end else begin
      stg_valid <= {stg_valid[STAGES-2:0], i_valid_d & ~i_kill_d & ~o_stall};
      stg_regwr <= {stg_regwr[STAGES-2:0], i_regwr_d};
      stg_load  <= {stg_load[STAGES-2:0], i_memread_d};
      stg_rw    <= {stg_rw[STAGES-2:0], i_rw_d};
    end
  end

  // Saturating stall-cycle counter. Clear has priority over counting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      stall_cnt <= '0;
    end else if (o_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Testbench for pipeline_hazard_unit.
// Two instances share the decode stimulus:
//   dut  : default parameters (3 stages, loads forward from MEM)
//   dut5 : 5 stages, loads forward from stage 3, 4-bit counter
// Expectations are queued when a cycle's stimulus is driven and are compared at
// the following falling edge.
module tb_pipeline_hazard_unit;

  localparam int F_ASRC  = 0;
  localparam int F_BSRC  = 1;
  localparam int F_STALL = 2;
  localparam int F_SRW   = 3;
  localparam int F_WBEN  = 4;
  localparam int F_WBRW  = 5;
  localparam int F_CNT   = 6;

  typedef struct {
    int          dut_id;
    int          field;
    logic [15:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_d, kill_d, use_rs, use_rt, regwr_d, memread_d, cnt_clr;
  logic [4:0] rs, rt, rw_d;

  logic [1:0]  asrc, bsrc;
  logic        stall, wb_en;
  logic [2:0]  stage_regwr;
  logic [4:0]  wb_rw;
  logic [15:0] stall_cnt;

  logic [2:0]  asrc5, bsrc5;
  logic        stall5, wb_en5;
  logic [4:0]  stage_regwr5;
  logic [4:0]  wb_rw5;
  logic [3:0]  stall_cnt5;

  always #5 clk = ~clk;

  pipeline_hazard_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_d(valid_d), .i_kill_d(kill_d),
    .i_rs(rs), .i_rt(rt), .i_use_rs(use_rs), .i_use_rt(use_rt),
    .i_rw_d(rw_d), .i_regwr_d(regwr_d), .i_memread_d(memread_d), .i_cnt_clr(cnt_clr),
    .o_asrc(asrc), .o_bsrc(bsrc), .o_stall(stall), .o_stage_regwr(stage_regwr),
    .o_wb_en(wb_en), .o_wb_rw(wb_rw), .o_stall_cnt(stall_cnt)
  );

  pipeline_hazard_unit #(
    .REG_AW(5), .STAGES(5), .LOAD_STAGE(3), .CNT_W(4), .SEL_W(3)
  ) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_d(valid_d), .i_kill_d(kill_d),
    .i_rs(rs), .i_rt(rt), .i_use_rs(use_rs), .i_use_rt(use_rt),
    .i_rw_d(rw_d), .i_regwr_d(regwr_d), .i_memread_d(memread_d), .i_cnt_clr(cnt_clr),
    .o_asrc(asrc5), .o_bsrc(bsrc5), .o_stall(stall5), .o_stage_regwr(stage_regwr5),
    .o_wb_en(wb_en5), .o_wb_rw(wb_rw5), .o_stall_cnt(stall_cnt5)
  );

  // Current value of one output field of one instance.
  function automatic logic [15:0] obs(input int d, input int f);
    logic [15:0] r;
    r = '0;
    if (d == 0) begin
      case (f)
        F_ASRC:  r = 16'(asrc);
        F_BSRC:  r = 16'(bsrc);
        F_STALL: r = 16'(stall);
        F_SRW:   r = 16'(stage_regwr);
        F_WBEN:  r = 16'(wb_en);
        F_WBRW:  r = 16'(wb_rw);
        default: r = stall_cnt;
      endcase
    end else begin
      case (f)
        F_ASRC:  r = 16'(asrc5);
        F_BSRC:  r = 16'(bsrc5);
        F_STALL: r = 16'(stall5);
        F_SRW:   r = 16'(stage_regwr5);
        F_WBEN:  r = 16'(wb_en5);
        F_WBRW:  r = 16'(wb_rw5);
        default: r = 16'(stall_cnt5);
      endcase
    end
    return r;
  endfunction

  function automatic string fname(input int f);
    case (f)
      F_ASRC:  return "asrc";
      F_BSRC:  return "bsrc";
      F_STALL: return "stall";
      F_SRW:   return "stage_regwr";
      F_WBEN:  return "wb_en";
      F_WBRW:  return "wb_rw";
      default: return "stall_cnt";
    endcase
  endfunction

  // Queue one expected value for the upcoming sample point.
  task automatic want(input int d, input int f, input logic [15:0] v);
    exp_t e;
    e.dut_id = d;
    e.field  = f;
    e.value  = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic k, input logic [4:0] s, input logic [4:0] t,
                       input logic us, input logic ut, input logic [4:0] w,
                       input logic wr, input logic ld, input logic clr);
    valid_d = v; kill_d = k; rs = s; rt = t; use_rs = us; use_rt = ut;
    rw_d = w; regwr_d = wr; memread_d = ld; cnt_clr = clr;
  endtask

  // Idle decode cycles so that every tracked stage drains.
  task automatic flush(input int n, input logic clr);
    repeat (n) begin
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, clr);
    end
  endtask

  task automatic test_reset;
    exp_t e;
    logic [15:0] got;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    want(0, F_ASRC, 0); want(0, F_BSRC, 0); want(0, F_STALL, 0); want(0, F_SRW, 0);
    want(0, F_WBEN, 0); want(0, F_WBRW, 0); want(0, F_CNT, 0);
    want(1, F_SRW, 0); want(1, F_CNT, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = obs(e.dut_id, e.field); n_checks++;
      if (got !== e.value) begin
        n_fail++;
        $display("[TB] FAIL reset dut%0d %s: got 0x%0h expected 0x%0h", e.dut_id, fname(e.field), got, e.value);
      end
    end
    rst_n = 1'b1;
  endtask

  // ALU producer r5, followed by readers seeing it in EX, MEM, WB and then gone.
  task automatic test_forward;
    exp_t e;
    logic [15:0] got;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      case (c)
        0: begin drive(1, 0, 0, 0, 0, 0, 5, 1, 0, 0); want(0, F_STALL, 0); end
        1: begin drive(1, 0, 5, 0, 1, 0, 9, 0, 0, 0);
                 want(0, F_ASRC, 1); want(0, F_STALL, 0); want(0, F_SRW, 3'b001); end
        2: begin drive(1, 0, 5, 0, 1, 0, 9, 0, 0, 0);
                 want(0, F_ASRC, 2); want(0, F_SRW, 3'b010); end
        3: begin drive(1, 0, 5, 0, 1, 0, 9, 0, 0, 0);
                 want(0, F_ASRC, 3); want(0, F_WBEN, 1); want(0, F_WBRW, 5); end
        default: begin drive(1, 0, 5, 0, 1, 0, 9, 0, 0, 0);
                 want(0, F_ASRC, 0); want(0, F_WBEN, 0); end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = obs(e.dut_id, e.field); n_checks++;
        if (got !== e.value) begin
          n_fail++;
          $display("[TB] FAIL forward c%0d dut%0d %s: got 0x%0h expected 0x%0h", c, e.dut_id, fname(e.field), got, e.value);
        end
      end
    end
  endtask

  // lw r7 then a reader of rt=r7 gives one stall and a bubble, then MEM bypass.
  task automatic test_load_use;
    exp_t e;
    logic [15:0] got;
    flush(3, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      case (c)
        0: begin drive(1, 0, 0, 0, 0, 0, 7, 1, 1, 0); want(0, F_STALL, 0); end
        1: begin drive(1, 0, 0, 7, 0, 1, 8, 1, 0, 0);
                 want(0, F_STALL, 1); want(0, F_BSRC, 1); want(0, F_SRW, 3'b001); end
        2: begin drive(1, 0, 0, 7, 0, 1, 8, 1, 0, 0);
                 want(0, F_STALL, 0); want(0, F_BSRC, 2); want(0, F_SRW, 3'b010); want(0, F_CNT, 1); end
        default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                 want(0, F_SRW, 3'b101); want(0, F_WBEN, 1); want(0, F_WBRW, 7); want(0, F_CNT, 1); end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = obs(e.dut_id, e.field); n_checks++;
        if (got !== e.value) begin
          n_fail++;
          $display("[TB] FAIL load_use c%0d dut%0d %s: got 0x%0h expected 0x%0h", c, e.dut_id, fname(e.field), got, e.value);
        end
      end
    end
  endtask

  // r3 in stages 1 and 3 with r9 in stage 2, followed by a producer and reader of r0.
  task automatic test_youngest;
    exp_t e;
    logic [15:0] got;
    flush(3, 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      case (c)
        0: drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 0);
        1: drive(1, 0, 0, 0, 0, 0, 9, 1, 0, 0);
        2: drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 0);
        3: begin drive(1, 0, 3, 9, 1, 1, 4, 0, 0, 0);
                 want(0, F_ASRC, 1); want(0, F_BSRC, 2); want(0, F_STALL, 0); end
        4: drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        default: begin drive(1, 0, 0, 0, 1, 1, 4, 0, 0, 0);
                 want(0, F_ASRC, 0); want(0, F_BSRC, 0); want(0, F_SRW, 3'b101); end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = obs(e.dut_id, e.field); n_checks++;
        if (got !== e.value) begin
          n_fail++;
          $display("[TB] FAIL youngest c%0d dut%0d %s: got 0x%0h expected 0x%0h", c, e.dut_id, fname(e.field), got, e.value);
        end
      end
    end
  endtask

  // A killed hazard does not stall and leaves a bubble. Counter clear beats an increment.
  task automatic test_kill_and_clear;
    exp_t e;
    logic [15:0] got;
    flush(3, 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      case (c)
        0: drive(1, 0, 0, 0, 0, 0, 7, 1, 1, 0);
        1: begin drive(1, 1, 0, 7, 0, 1, 8, 1, 0, 0); want(0, F_STALL, 0); end
        2: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                 want(0, F_SRW, 3'b010); want(0, F_CNT, 1); end
        3: drive(1, 0, 0, 0, 0, 0, 7, 1, 1, 0);
        4: begin drive(1, 0, 0, 7, 0, 1, 8, 1, 0, 1);
                 want(0, F_STALL, 1); want(0, F_BSRC, 1); want(0, F_CNT, 1); end
        default: begin drive(1, 0, 0, 7, 0, 1, 8, 1, 0, 0);
                 want(0, F_STALL, 0); want(0, F_BSRC, 2); want(0, F_CNT, 0); end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = obs(e.dut_id, e.field); n_checks++;
        if (got !== e.value) begin
          n_fail++;
          $display("[TB] FAIL kill_clear c%0d dut%0d %s: got 0x%0h expected 0x%0h", c, e.dut_id, fname(e.field), got, e.value);
        end
      end
    end
  endtask

  // Five stages with load data from stage 3: two stalls per load-use pair, and the counter saturates.
  task automatic test_deep_pipeline;
    exp_t e;
    logic [15:0] got;
    flush(6, 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      case (c)
        0: begin drive(1, 0, 0, 0, 0, 0, 7, 1, 1, 0); want(1, F_STALL, 0); want(1, F_CNT, 0); end
        1: begin drive(1, 0, 0, 7, 0, 1, 8, 1, 0, 0); want(1, F_STALL, 1); want(1, F_BSRC, 1); end
        2: begin drive(1, 0, 0, 7, 0, 1, 8, 1, 0, 0);
                 want(1, F_STALL, 1); want(1, F_BSRC, 2); want(1, F_SRW, 5'b00010); want(1, F_CNT, 1); end
        default: begin drive(1, 0, 0, 7, 0, 1, 8, 1, 0, 0);
                 want(1, F_STALL, 0); want(1, F_BSRC, 3); want(1, F_CNT, 2); end
      endcase
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = obs(e.dut_id, e.field); n_checks++;
        if (got !== e.value) begin
          n_fail++;
          $display("[TB] FAIL deep c%0d dut%0d %s: got 0x%0h expected 0x%0h", c, e.dut_id, fname(e.field), got, e.value);
        end
      end
    end
    for (int it = 0; it < 10; it++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (c == 0) drive(1, 0, 0, 0, 0, 0, 7, 1, 1, 0);
        else        drive(1, 0, 0, 7, 0, 1, 8, 1, 0, 0);
      end
      if (it == 5) want(1, F_CNT, 14);
      if (it == 9) want(1, F_CNT, 15);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = obs(e.dut_id, e.field); n_checks++;
        if (got !== e.value) begin
          n_fail++;
          $display("[TB] FAIL deep_sat it%0d dut%0d %s: got 0x%0h expected 0x%0h", it, e.dut_id, fname(e.field), got, e.value);
        end
      end
    end
  endtask

  // Reset mid-cycle while a load sits in MEM. Nothing in flight may write back afterwards.
  task automatic test_reset_midflight;
    exp_t e;
    logic [15:0] got;
    flush(3, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (c == 0) drive(1, 0, 0, 0, 0, 0, 7, 1, 1, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (c == 2) want(0, F_SRW, 3'b010);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = obs(e.dut_id, e.field); n_checks++;
        if (got !== e.value) begin
          n_fail++;
          $display("[TB] FAIL pre_reset dut%0d %s: got 0x%0h expected 0x%0h", e.dut_id, fname(e.field), got, e.value);
        end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    want(0, F_SRW, 0); want(0, F_WBEN, 0); want(0, F_WBRW, 0); want(0, F_CNT, 0);
    want(0, F_STALL, 0); want(0, F_ASRC, 0); want(0, F_BSRC, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); got = obs(e.dut_id, e.field); n_checks++;
      if (got !== e.value) begin
        n_fail++;
        $display("[TB] FAIL async_reset dut%0d %s: got 0x%0h expected 0x%0h", e.dut_id, fname(e.field), got, e.value);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      want(0, F_WBEN, 0); want(0, F_SRW, 0);
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = obs(e.dut_id, e.field); n_checks++;
        if (got !== e.value) begin
          n_fail++;
          $display("[TB] FAIL post_reset c%0d dut%0d %s: got 0x%0h expected 0x%0h", c, e.dut_id, fname(e.field), got, e.value);
        end
      end
    end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    rst_n = 1'b0;
    test_reset;
    test_forward;
    test_load_use;
    test_youngest;
    test_kill_and_clear;
    test_deep_pipeline;
    test_reset_midflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a run that never reaches the summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
